spi_master: RTL and testbench

- Byte-stream SPI master that drives the shared `spi_interface` through its Master modport.
- Sits between on-chip logic and the SPI pins: serialises words from a valid/ready TX stream and returns received words as RX pulses.
- Frames multi-word transactions on a selectable chip-select line.
- Configurable SPI mode (CPOL/CPHA), word width and SCK rate.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_if.sv | 15 +
 rtl/spi_clk_gen.sv | 30 +++
 rtl/spi_master.sv | 118 +++++++++++
 tb/tb_spi_master.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master block: FSM state encoding and the
// chip-select index width helper.
// Ports: none (package).
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    HOLD
  } spi_master_state_t;

  // Width of a chip-select index; at least one bit even for a single CS line.
  function automatic int cs_sel_width(input int cs_count);
    return (cs_count > 1) ? $clog2(cs_count) : 1;
  endfunction

endpackage

// File: rtl/spi_if.sv
// SPI pin bundle shared by master and slave sides.
// Ports: sck, mosi, cs[CS_COUNT-1:0] driven by Master; miso driven by Slave.
interface spi_interface #(
  parameter int CS_COUNT = 1
);

  logic                sck;
  logic                mosi;
  logic                miso;
  logic [CS_COUNT-1:0] cs;

  modport Master (output sck, output mosi, output cs, input miso);
  modport Slave  (input sck, input mosi, input cs, output miso);

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timer: counts 0..CLK_DIV-1 while enabled, strobes at terminal count.
// Latency: first strobe CLK_DIV cycles after enable rises from a cleared count.
// Backpressure: none; clear holds the count at zero.
// Ports: clk, reset (sync, active-high), clear, enable in; strobe out (1 cycle).
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic strobe
);

  localparam int            CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
    end
  end

  assign strobe = enable && (cnt == TC);

endmodule

// File: rtl/spi_master.sv
// SPI master: serialises TX stream words MSB first, returns RX words as pulses.
// Latency: 1 + CLK_DIV*(1 + 2*DATA_WIDTH) cycles from TX accept to rx_valid.
// Backpressure: tx_ready only in IDLE/GAP; rx_valid is a pulse with no backpressure.
// Ports: clk, reset; tx_data/tx_cs_sel/tx_last/tx_valid -> tx_ready;
//        rx_data/rx_valid; busy; spi (Master modport: sck, mosi, cs out, miso in).
module spi_master
  import spi_pkg::*;
#(
  parameter int CS_COUNT   = 1,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              tx_data,
  input  logic [cs_sel_width(CS_COUNT)-1:0]  tx_cs_sel,
  input  logic                               tx_last,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic [DATA_WIDTH-1:0]              rx_data,
  output logic                               rx_valid,
  output logic                               busy,
  spi_interface.Master                       spi
);

  localparam int            EW        = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

  spi_master_state_t     state;
  logic [DATA_WIDTH-1:0] sh;        // TX bits leave from the MSB, RX bits enter at the LSB
  logic                  last_q;
  logic [EW-1:0]         edge_cnt;  // even = leading edge, odd = trailing edge
  logic                  strobe;

  assign tx_ready = (state == IDLE) || (state == GAP);
  assign busy     = (state != IDLE);

  // Timer only runs in the timed states; holding it clear in IDLE/GAP makes
  // every timed state start from a zero count.
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (tx_ready),
    .enable (!tx_ready),
    .strobe (strobe)
  );

  always_ff @(posedge clk) begin
    rx_valid <= 1'b0;
    if (reset) begin
      state    <= IDLE;
      spi.sck  <= CPOL;
      spi.mosi <= 1'b0;
      spi.cs   <= '1;
      rx_data  <= '0;
      sh       <= '0;
      last_q   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            sh       <= tx_data;
            last_q   <= tx_last;
            edge_cnt <= '0;
            if (!CPHA) spi.mosi <= tx_data[DATA_WIDTH-1];
            // An out-of-range index matches no line, so no CS is asserted.
            for (int i = 0; i < CS_COUNT; i++) begin
              spi.cs[i] <= (int'(tx_cs_sel) != i);
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (strobe) state <= SHIFT;
        end
        SHIFT: begin
          if (strobe) begin
            spi.sck  <= ~spi.sck;
            edge_cnt <= edge_cnt + 1'b1;
            if (!edge_cnt[0]) begin
              if (CPHA) spi.mosi <= sh[DATA_WIDTH-1];
              else      sh       <= {sh[DATA_WIDTH-2:0], spi.miso};
            end else begin
              if (CPHA)                         sh       <= {sh[DATA_WIDTH-2:0], spi.miso};
              else if (edge_cnt != LAST_EDGE)   spi.mosi <= sh[DATA_WIDTH-1];
            end
            if (edge_cnt == LAST_EDGE) begin
              rx_valid <= 1'b1;
              // With CPHA=1 the final sample lands on this very edge.
              rx_data  <= CPHA ? {sh[DATA_WIDTH-2:0], spi.miso} : sh;
              state    <= last_q ? HOLD : GAP;
            end
          end
        end
        GAP: begin
          if (tx_valid) begin
            sh       <= tx_data;
            last_q   <= tx_last;
            edge_cnt <= '0;
            if (!CPHA) spi.mosi <= tx_data[DATA_WIDTH-1];
            state <= SETUP;
          end
        end
        HOLD: begin
          if (strobe) begin
            spi.cs <= '1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: mode 0, 4 CS, CLK_DIV=2, loopback ----------------
  spi_interface #(.CS_COUNT(4)) ifa ();
  assign ifa.miso = ifa.mosi;
  logic       a_rst = 1'b1;
  logic [7:0] a_tx_data = '0;
  logic [1:0] a_sel = '0;
  logic       a_last = 1'b0, a_tx_valid = 1'b0;
  logic       a_tx_ready, a_rx_valid, a_busy;
  logic [7:0] a_rx_data;

  spi_master #(.CS_COUNT(4), .DATA_WIDTH(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
    .clk(clk), .reset(a_rst), .tx_data(a_tx_data), .tx_cs_sel(a_sel), .tx_last(a_last),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .busy(a_busy), .spi(ifa));

  // ---------------- DUT B: mode 3, 1 CS, CLK_DIV=2, slave model ----------------
  spi_interface #(.CS_COUNT(1)) ifb ();
  logic       b_rst = 1'b1;
  logic [7:0] b_tx_data = '0;
  logic [0:0] b_sel = '0;
  logic       b_last = 1'b0, b_tx_valid = 1'b0;
  logic       b_tx_ready, b_rx_valid, b_busy;
  logic [7:0] b_rx_data;
  logic [7:0] b_pat = 8'h3C;
  int         b_bit = 7;

  spi_master #(.CS_COUNT(1), .DATA_WIDTH(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
    .clk(clk), .reset(b_rst), .tx_data(b_tx_data), .tx_cs_sel(b_sel), .tx_last(b_last),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .busy(b_busy), .spi(ifb));

  // Mode-3 slave: shift out on the leading (falling) edge, MSB first.
  initial ifb.miso = 1'b0;
  always @(negedge ifb.sck) begin
    ifb.miso = b_pat[b_bit];
    b_bit    = (b_bit == 0) ? 7 : b_bit - 1;
  end

  // ---------------- DUT C: mode 0, 3 CS, CLK_DIV=1, loopback ----------------
  spi_interface #(.CS_COUNT(3)) ifc ();
  assign ifc.miso = ifc.mosi;
  logic       c_rst = 1'b1;
  logic [7:0] c_tx_data = '0;
  logic [1:0] c_sel = '0;
  logic       c_last = 1'b0, c_tx_valid = 1'b0;
  logic       c_tx_ready, c_rx_valid, c_busy;
  logic [7:0] c_rx_data;

  spi_master #(.CS_COUNT(3), .DATA_WIDTH(8), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0)) dut_c (
    .clk(clk), .reset(c_rst), .tx_data(c_tx_data), .tx_cs_sel(c_sel), .tx_last(c_last),
    .tx_valid(c_tx_valid), .tx_ready(c_tx_ready), .rx_data(c_rx_data), .rx_valid(c_rx_valid),
    .busy(c_busy), .spi(ifc));

  // ---------------- pin monitors ----------------
  logic       a_sck_q = 1'b0;
  int         a_rises = 0, a_rx_cnt = 0;
  logic [7:0] a_mosi_cap = '0;
  logic       b_sck_q = 1'b1, b_mosi_q = 1'b0;
  int         b_bad_mosi = 0;

  always @(negedge clk) begin
    a_sck_q <= ifa.sck;
    if (!a_sck_q && ifa.sck) begin
      a_rises    <= a_rises + 1;
      a_mosi_cap <= {a_mosi_cap[6:0], ifa.mosi};
    end
    if (a_rx_valid) a_rx_cnt <= a_rx_cnt + 1;
    b_sck_q  <= ifb.sck;
    b_mosi_q <= ifb.mosi;
    if (!b_rst && (ifb.mosi !== b_mosi_q) && !(b_sck_q && !ifb.sck)) b_bad_mosi <= b_bad_mosi + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- transfer helpers ----------------
  task automatic a_xfer(input logic [7:0] d, input logic [1:0] sel, input logic last,
                        input logic [3:0] cs_exp, output logic [7:0] rx,
                        output int t_acc, output int t_rx, output bit cs_ok);
    cs_ok = 1'b1;
    rx    = '0;
    for (int k = 0; k < 100 && !a_tx_ready; k++) @(negedge clk);
    a_tx_data = d; a_sel = sel; a_last = last; a_tx_valid = 1'b1;
    t_acc = cyc;
    t_rx  = t_acc - 1000;
    @(negedge clk);
    a_tx_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (ifa.cs !== cs_exp) cs_ok = 1'b0;
      if (a_rx_valid) begin
        rx   = a_rx_data;
        t_rx = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic a_wait_cs_high(input int t_ref, output int dt);
    dt = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ifa.cs === 4'hF) begin
        dt = cyc - t_ref;
        break;
      end
    end
  endtask

  task automatic b_xfer(input logic [7:0] d, output logic [7:0] rx, output int lat);
    int t_acc;
    rx  = '0;
    lat = -1;
    for (int k = 0; k < 100 && !b_tx_ready; k++) @(negedge clk);
    b_tx_data = d; b_sel = 1'b0; b_last = 1'b1; b_tx_valid = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    b_tx_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (b_rx_valid) begin
        rx  = b_rx_data;
        lat = cyc - t_acc;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    logic [3:0] cs_exp;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] rx;
    int         t_acc, t_rx, dt, r0, rc0, viol, ne, lat;
    bit         cs_ok;
    logic       prev;
    int         acct [2];
    int         rxt  [2];
    logic [7:0] rxd  [2];
    int         acc, rxn, gap_hi;

    vecs[0] = '{8'hA5, 2'd0, 4'b1110, 8'hA5};
    vecs[1] = '{8'h3C, 2'd1, 4'b1101, 8'h3C};
    vecs[2] = '{8'h00, 2'd3, 4'b0111, 8'h00};
    vecs[3] = '{8'hFF, 2'd2, 4'b1011, 8'hFF};
    vecs[4] = '{8'h81, 2'd0, 4'b1110, 8'h81};

    repeat (3) @(negedge clk);
    chk("a_rst_cs", ifa.cs, 4'hF);
    chk("a_rst_sck", ifa.sck, 1'b0);
    chk("a_rst_mosi", ifa.mosi, 1'b0);
    chk("a_rst_rx_valid", a_rx_valid, 1'b0);
    chk("a_rst_rx_data", a_rx_data, 8'h00);
    chk("a_rst_busy", a_busy, 1'b0);
    chk("b_rst_sck", ifb.sck, 1'b1);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    @(negedge clk);
    chk("a_ready_after_rst", a_tx_ready, 1'b1);

    // Single-word transactions, mode 0 loopback.
    for (int i = 0; i < 5; i++) begin
      r0 = a_rises;
      a_xfer(vecs[i].data, vecs[i].sel, 1'b1, vecs[i].cs_exp, rx, t_acc, t_rx, cs_ok);
      chk($sformatf("v%0d_rx", i), rx, vecs[i].exp_rx);
      chk($sformatf("v%0d_latency", i), t_rx - t_acc, 35);
      chk($sformatf("v%0d_cs_held", i), cs_ok, 1'b1);
      chk($sformatf("v%0d_sck_rises", i), a_rises - r0, 8);
      chk($sformatf("v%0d_mosi_bits", i), a_mosi_cap, vecs[i].data);
      a_wait_cs_high(t_acc, dt);
      chk($sformatf("v%0d_cs_rise", i), dt, 37);
    end

    // Three-word transaction on CS 2 with a 20-cycle stall in GAP.
    rc0 = a_rx_cnt;
    a_xfer(8'h11, 2'd2, 1'b0, 4'b1011, rx, t_acc, t_rx, cs_ok);
    chk("w1_rx", rx, 8'h11);
    chk("w1_cs", cs_ok, 1'b1);
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifa.cs !== 4'b1011 || ifa.sck !== 1'b0 || a_tx_ready !== 1'b1 || a_busy !== 1'b1) viol++;
    end
    chk("gap_stall", viol, 0);
    a_xfer(8'h22, 2'd0, 1'b0, 4'b1011, rx, t_acc, t_rx, cs_ok);
    chk("w2_rx", rx, 8'h22);
    chk("w2_latency", t_rx - t_acc, 35);
    chk("w2_cs", cs_ok, 1'b1);
    a_xfer(8'h33, 2'd1, 1'b1, 4'b1011, rx, t_acc, t_rx, cs_ok);
    chk("w3_rx", rx, 8'h33);
    chk("w3_cs", cs_ok, 1'b1);
    a_wait_cs_high(t_rx, dt);
    chk("w3_cs_hold", dt, 2);
    repeat (3) @(negedge clk);
    chk("w_rx_pulses", a_rx_cnt - rc0, 3);

    // Reset on the 5th sck edge aborts the word.
    for (int k = 0; k < 100 && !a_tx_ready; k++) @(negedge clk);
    a_tx_data = 8'hFF; a_sel = 2'd0; a_last = 1'b1; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    prev = ifa.sck;
    ne   = 0;
    for (int k = 0; k < 100 && ne < 5; k++) begin
      @(negedge clk);
      if (ifa.sck !== prev) ne++;
      prev = ifa.sck;
    end
    chk("rst_edge5_reached", ne, 5);
    rc0   = a_rx_cnt;
    a_rst = 1'b1;
    @(negedge clk);
    chk("abort_cs", ifa.cs, 4'hF);
    chk("abort_sck", ifa.sck, 1'b0);
    chk("abort_mosi", ifa.mosi, 1'b0);
    chk("abort_busy", a_busy, 1'b0);
    a_rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", a_tx_ready, 1'b1);
    repeat (60) @(negedge clk);
    chk("abort_no_rx", a_rx_cnt - rc0, 0);
    a_xfer(8'h5A, 2'd1, 1'b1, 4'b1101, rx, t_acc, t_rx, cs_ok);
    chk("post_abort_rx", rx, 8'h5A);
    chk("post_abort_latency", t_rx - t_acc, 35);

    // Mode 3 against the slave model.
    b_pat = 8'h3C;
    b_xfer(8'hFF, rx, lat);
    chk("m3_rx_3c", rx, 8'h3C);
    chk("m3_latency", lat, 35);
    chk("m3_sck_idle_high", ifb.sck, 1'b1);
    chk("m3_mosi_sent", ifb.mosi, 1'b1);
    for (int k = 0; k < 100 && ifb.cs[0] !== 1'b1; k++) @(negedge clk);
    b_pat = 8'hA1;
    b_xfer(8'h00, rx, lat);
    chk("m3_rx_a1", rx, 8'hA1);
    repeat (4) @(negedge clk);
    chk("m3_mosi_on_fall_only", b_bad_mosi, 0);

    // CLK_DIV=1, back-to-back single-word transactions with tx_valid held high.
    acc = 0; rxn = 0; gap_hi = 0;
    acct[0] = 0; acct[1] = 0; rxt[0] = 0; rxt[1] = 0; rxd[0] = '0; rxd[1] = '0;
    c_tx_data = 8'h96; c_sel = 2'd1; c_last = 1'b1; c_tx_valid = 1'b1;
    for (int k = 0; k < 100 && rxn < 2; k++) begin
      if (c_rx_valid) begin
        rxd[rxn] = c_rx_data;
        rxt[rxn] = cyc;
        rxn++;
      end
      if (rxn == 1 && ifc.cs === 3'b111) gap_hi++;
      if (c_tx_ready && c_tx_valid && acc < 2) begin
        acct[acc] = cyc;
        acc++;
      end
      @(negedge clk);
      if (acc == 1) c_tx_data = 8'h0F;
      if (acc >= 2) c_tx_valid = 1'b0;
    end
    c_tx_valid = 1'b0;
    chk("b2b_rx0", rxd[0], 8'h96);
    chk("b2b_rx1", rxd[1], 8'h0F);
    chk("b2b_latency0", rxt[0] - acct[0], 18);
    chk("b2b_latency1", rxt[1] - acct[1], 18);
    chk("b2b_cs_gap", gap_hi >= 1, 1'b1);

    // Out-of-range chip select: word still clocks, no CS asserted.
    for (int k = 0; k < 100 && !c_tx_ready; k++) @(negedge clk);
    c_tx_data = 8'hC3; c_sel = 2'd3; c_last = 1'b1; c_tx_valid = 1'b1;
    @(negedge clk);
    c_tx_valid = 1'b0;
    viol = 0;
    rx   = '0;
    for (int k = 0; k < 100; k++) begin
      if (ifc.cs !== 3'b111) viol++;
      if (c_rx_valid) begin
        rx = c_rx_data;
        break;
      end
      @(negedge clk);
    end
    chk("oor_rx", rx, 8'hC3);
    chk("oor_no_cs", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
